// File: rtl/conditioned_shiftreg_pkg.sv
// Shared constants and helpers for the conditioned shift register.
package conditioned_shiftreg_pkg;

    localparam int unsigned DEFAULT_WIDTH           = 8;
    localparam int unsigned DEFAULT_SYNC_STAGES     = 2;
    localparam int unsigned DEFAULT_DEBOUNCE_CYCLES = 10;

    // Ceiling log2; clog2(1) = 0.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span << 1;
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/conditioned_shiftreg_input_conditioner.sv
// Synchroniser + debouncer + edge detector for one raw board input.
module input_conditioner
    import conditioned_shiftreg_pkg::*;
#(
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw,
    output logic cond,
    output logic pos,
    output logic neg
);

    localparam int unsigned CNT_W = clog2(DEBOUNCE_CYCLES) + 1;

    logic [SYNC_STAGES-1:0] sync;
    logic [CNT_W-1:0]       cnt;
    logic                   cond_d;
    logic                   sync_val;

    assign sync_val = sync[SYNC_STAGES-1];

    // Conditioned value only flips after DEBOUNCE_CYCLES consecutive differing samples.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync   <= '0;
            cnt    <= '0;
            cond   <= 1'b0;
            cond_d <= 1'b0;
        end else begin
            sync   <= {sync[SYNC_STAGES-2:0], raw};
            cond_d <= cond;
            if (sync_val == cond) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cond <= ~cond;
                cnt  <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

    assign pos = cond & ~cond_d;
    assign neg = ~cond & cond_d;

endmodule

// File: rtl/conditioned_shiftreg.sv
// Shift register driven by conditioned board inputs (serial clock, data, load).
// Optional status counter enabled by defining SHIFTREG_STATUS_EN.
module conditioned_shiftreg
    import conditioned_shiftreg_pkg::*;
#(
    parameter int unsigned WIDTH           = DEFAULT_WIDTH,
    parameter int unsigned SYNC_STAGES     = DEFAULT_SYNC_STAGES,
    parameter int unsigned DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES,
    parameter bit          MSB_FIRST       = 1'b1,
    localparam int unsigned BC_W           = clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sclk_raw,
    input  logic             sdata_raw,
    input  logic             load_raw,
    input  logic [WIDTH-1:0] parallel_in,
    output logic [WIDTH-1:0] parallel_out,
    output logic             serial_out,
`ifdef SHIFTREG_STATUS_EN
    output logic [BC_W-1:0]  bit_count,
    output logic             word_done,
`endif
    output logic             sclk_pos,
    output logic             sclk_neg
);

    logic sclk_cond;
    logic sdata_cond;
    logic sdata_pos;
    logic sdata_neg;
    logic load_cond;
    logic load_pos;
    logic load_neg;
    logic unused_cond_bits;

    input_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sclk (
        .clk  (clk),
        .reset(reset),
        .raw  (sclk_raw),
        .cond (sclk_cond),
        .pos  (sclk_pos),
        .neg  (sclk_neg)
    );

    input_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_sdata (
        .clk  (clk),
        .reset(reset),
        .raw  (sdata_raw),
        .cond (sdata_cond),
        .pos  (sdata_pos),
        .neg  (sdata_neg)
    );

    input_conditioner #(
        .SYNC_STAGES    (SYNC_STAGES),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_load (
        .clk  (clk),
        .reset(reset),
        .raw  (load_raw),
        .cond (load_cond),
        .pos  (load_pos),
        .neg  (load_neg)
    );

    assign unused_cond_bits = ^{sclk_cond, sdata_pos, sdata_neg, load_cond, load_neg};

    // Load edge outranks a coincident shift edge; the shift is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            parallel_out <= '0;
        end else if (load_pos) begin
            parallel_out <= parallel_in;
        end else if (sclk_pos) begin
            if (MSB_FIRST) begin
                parallel_out <= {parallel_out[WIDTH-2:0], sdata_cond};
            end else begin
                parallel_out <= {sdata_cond, parallel_out[WIDTH-1:1]};
            end
        end
    end

    assign serial_out = MSB_FIRST ? parallel_out[WIDTH-1] : parallel_out[0];

`ifdef SHIFTREG_STATUS_EN
    // Counts accepted shifts; wraps to zero with a one-cycle word_done at WIDTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            bit_count <= '0;
            word_done <= 1'b0;
        end else begin
            word_done <= 1'b0;
            if (load_pos) begin
                bit_count <= '0;
            end else if (sclk_pos) begin
                if (bit_count == BC_W'(WIDTH - 1)) begin
                    bit_count <= '0;
                    word_done <= 1'b1;
                end else begin
                    bit_count <= bit_count + BC_W'(1);
                end
            end
        end
    end
`endif

endmodule

// File: tb/tb_conditioned_shiftreg.sv
// Directed bench for conditioned_shiftreg (WIDTH=8, SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
// Status checks compile in when SHIFTREG_STATUS_EN is defined.
module tb_conditioned_shiftreg;

    localparam int unsigned WIDTH = 8;

    logic             clk = 1'b0;
    logic             reset;
    logic             sclk_raw;
    logic             sdata_raw;
    logic             load_raw;
    logic [WIDTH-1:0] parallel_in;
    logic [WIDTH-1:0] parallel_out;
    logic             serial_out;
    logic             sclk_pos;
    logic             sclk_neg;
`ifdef SHIFTREG_STATUS_EN
    logic [3:0]       bit_count;
    logic             word_done;
    int               done_count = 0;
`endif

    int tests_run    = 0;
    int tests_failed = 0;
    int pos_count    = 0;
    int neg_count    = 0;

    conditioned_shiftreg #(
        .WIDTH          (WIDTH),
        .SYNC_STAGES    (2),
        .DEBOUNCE_CYCLES(4),
        .MSB_FIRST      (1'b1)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .sclk_raw    (sclk_raw),
        .sdata_raw   (sdata_raw),
        .load_raw    (load_raw),
        .parallel_in (parallel_in),
        .parallel_out(parallel_out),
        .serial_out  (serial_out),
`ifdef SHIFTREG_STATUS_EN
        .bit_count   (bit_count),
        .word_done   (word_done),
`endif
        .sclk_pos    (sclk_pos),
        .sclk_neg    (sclk_neg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (sclk_pos === 1'b1) pos_count++;
        if (sclk_neg === 1'b1) neg_count++;
`ifdef SHIFTREG_STATUS_EN
        if (word_done === 1'b1) done_count++;
`endif
    end

    // One clock edge, then settle past it before driving/sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One clean serial clock period: data set with sclk low, then sclk high.
    task automatic shift_bit(input logic b);
        sdata_raw = b;
        sclk_raw  = 1'b0;
        repeat (8) step();
        sclk_raw = 1'b1;
        repeat (8) step();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        sclk_raw = 1'b1; sdata_raw = 1'b1; load_raw = 1'b1;
        parallel_in = 8'h3C;
        repeat (3) step();
        tests_run++;
        if (parallel_out !== 8'h00) begin
            tests_failed++;
            $display("FAIL reset_parallel_out got=%h exp=00", parallel_out);
        end
        tests_run++;
        if ({serial_out, sclk_pos, sclk_neg} !== 3'b000) begin
            tests_failed++;
            $display("FAIL reset_flags got=%b exp=000", {serial_out, sclk_pos, sclk_neg});
        end
        reset = 1'b0;
        repeat (5) step();
        tests_run++;
        if (sclk_pos !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_early_pos got=%b exp=0", sclk_pos);
        end
        step();
        tests_run++;
        if (sclk_pos !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_latency_pos got=%b exp=1", sclk_pos);
        end
        step();
        tests_run++;
        if (parallel_out !== 8'h3C || sclk_pos !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_release_load got=%h/%b exp=3c/0", parallel_out, sclk_pos);
        end
        sclk_raw = 1'b0; sdata_raw = 1'b0; load_raw = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_glitch();
        int pc0;
        pc0 = pos_count;
        sclk_raw = 1'b1;
        repeat (3) step();
        sclk_raw = 1'b0;
        repeat (12) step();
        tests_run++;
        if (pos_count !== pc0 || parallel_out !== 8'h3C) begin
            tests_failed++;
            $display("FAIL glitch_reject pulses=%0d exp=0 po=%h exp=3c", pos_count - pc0, parallel_out);
        end
        sclk_raw = 1'b1;
        repeat (5) step();
        sclk_raw = 1'b0;
        repeat (12) step();
        tests_run++;
        if (pos_count !== pc0 + 1 || parallel_out !== 8'h78) begin
            tests_failed++;
            $display("FAIL glitch_accept pulses=%0d exp=1 po=%h exp=78", pos_count - pc0, parallel_out);
        end
    endtask

    task automatic test_serial_shift();
        logic [7:0] bits;
        int pc0, nc0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        step();
        pc0 = pos_count;
        nc0 = neg_count;
        bits = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) shift_bit(bits[i]);
        sclk_raw = 1'b0;
        repeat (10) step();
        tests_run++;
        if (parallel_out !== 8'hB2) begin
            tests_failed++;
            $display("FAIL serial_word got=%h exp=b2", parallel_out);
        end
        tests_run++;
        if (serial_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL serial_out got=%b exp=1", serial_out);
        end
        tests_run++;
        if (pos_count - pc0 !== 8 || neg_count - nc0 !== 8) begin
            tests_failed++;
            $display("FAIL serial_pulse_count pos=%0d neg=%0d exp=8/8", pos_count - pc0, neg_count - nc0);
        end
    endtask

    task automatic test_load_collision();
        parallel_in = 8'h5A;
        load_raw = 1'b1;
        sclk_raw = 1'b1;
        repeat (10) step();
        tests_run++;
        if (parallel_out !== 8'h5A) begin
            tests_failed++;
            $display("FAIL load_collision got=%h exp=5a", parallel_out);
        end
        load_raw = 1'b0;
        sclk_raw = 1'b0;
        sdata_raw = 1'b1;
        repeat (10) step();
        sclk_raw = 1'b1;
        repeat (10) step();
        tests_run++;
        if (parallel_out !== 8'hB5) begin
            tests_failed++;
            $display("FAIL load_then_shift got=%h exp=b5", parallel_out);
        end
        sclk_raw = 1'b0;
        repeat (10) step();
    endtask

    task automatic test_reset_mid();
        int early;
        sclk_raw = 1'b1;
        repeat (4) step();
        reset = 1'b1;
        step();
        tests_run++;
        if (parallel_out !== 8'h00 || sclk_pos !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_clear po=%h pos=%b exp=00/0", parallel_out, sclk_pos);
        end
        repeat (2) step();
        reset = 1'b0;
        early = 0;
        for (int i = 0; i < 5; i++) begin
            step();
            if (sclk_pos !== 1'b0) early++;
        end
        tests_run++;
        if (early !== 0) begin
            tests_failed++;
            $display("FAIL reset_mid_early_pulse got=%0d exp=0", early);
        end
        step();
        tests_run++;
        if (sclk_pos !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_mid_full_latency got=%b exp=1", sclk_pos);
        end
        step();
        tests_run++;
        if (parallel_out !== 8'h01) begin
            tests_failed++;
            $display("FAIL reset_mid_shift got=%h exp=01", parallel_out);
        end
        sclk_raw = 1'b0;
        repeat (10) step();
    endtask

`ifdef SHIFTREG_STATUS_EN
    task automatic test_status();
        int d0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        d0 = done_count;
        for (int i = 1; i <= 8; i++) begin
            sdata_raw = 1'b0;
            sclk_raw  = 1'b0;
            repeat (8) step();
            sclk_raw = 1'b1;
            repeat (7) step();
            tests_run++;
            if (bit_count !== 4'(i % 8) || word_done !== (i == 8)) begin
                tests_failed++;
                $display("FAIL status_shift%0d count=%0d done=%b exp=%0d/%b",
                         i, bit_count, word_done, i % 8, (i == 8));
            end
            step();
        end
        tests_run++;
        if (done_count - d0 !== 1) begin
            tests_failed++;
            $display("FAIL status_done_pulses got=%0d exp=1", done_count - d0);
        end
        d0 = done_count;
        for (int i = 0; i < 5; i++) shift_bit(1'b1);
        sclk_raw = 1'b0;
        repeat (10) step();
        parallel_in = 8'hC3;
        load_raw = 1'b1;
        repeat (10) step();
        load_raw = 1'b0;
        repeat (10) step();
        tests_run++;
        if (bit_count !== 4'd0 || done_count !== d0 || parallel_out !== 8'hC3) begin
            tests_failed++;
            $display("FAIL status_load_clear count=%0d done=%0d po=%h exp=0/0/c3",
                     bit_count, done_count - d0, parallel_out);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_glitch();
        test_serial_shift();
        test_load_collision();
        test_reset_mid();
`ifdef SHIFTREG_STATUS_EN
        test_status();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
